// File: rtl/time_set_ctrl.sv
// time_set_ctrl: push-button hour/minute setting front end with debounced keys, field blink and timed load.
// Optional macro TSET_AUTOREPEAT_EN: a held up/down key auto-repeats while a field is being edited.
module time_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LOAD_CYCLES     = 50000000,
   parameter int BLINK_CYCLES    = 12500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       key_mode_n,
   input  logic       key_up_n,
   input  logic       key_down_n,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic [4:0] edit_hour,
   output logic [5:0] edit_min,
   output logic       load,
   output logic       editing,
   output logic       blink_hour,
   output logic       blink_min
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LW = $clog2(LOAD_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;
   state_t state;
   logic [2:0] raw, s1, s2, deb, deb_d, strobe;
   logic [LW-1:0] lcnt;
   logic [BW-1:0] bcnt;
   logic phase, mode_s, up_s, dn_s, rpt, step_up, step_dn, load_done, chg;
   assign raw = ~{key_down_n, key_up_n, key_mode_n};
   assign strobe = deb & ~deb_d;
   assign mode_s = strobe[0];
   assign up_s = strobe[1];
   assign dn_s = strobe[2];
   assign step_up = (up_s & ~dn_s) | (rpt & deb[1]);
   assign step_dn = (dn_s & ~up_s) | (rpt & deb[2]);
   assign load_done = (state == COMMIT) && (lcnt == LW'(LOAD_CYCLES - 1));
   assign chg = mode_s ? (state != COMMIT) : load_done;
   assign blink_hour = (state == EDIT_HOUR) & phase;
   assign blink_min = (state == EDIT_MIN) & phase;
   // two-flop synchronizers for the raw keys and the previous debounced level for edge detection
   always_ff @(posedge CLOCK_50 or negedge rst_n)
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         deb_d <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         deb_d <= deb;
      end
   genvar k;
   generate
      for (k = 0; k < 3; k++) begin : g_deb
         logic [DW-1:0] cnt;
         logic lvl;
         assign deb[k] = lvl;
         // debounced level follows the synchronized key only after a full stable run
         always_ff @(posedge CLOCK_50 or negedge rst_n)
            if (!rst_n) begin
               cnt <= '0;
               lvl <= 1'b0;
            end else if (s2[k] == lvl) begin
               cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               cnt <= '0;
               lvl <= s2[k];
            end else begin
               cnt <= cnt + 1'b1;
            end
      end
   endgenerate
`ifdef TSET_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
   logic [RW-1:0] rcnt;
   logic first, run;
   assign run = ((state == EDIT_HOUR) || (state == EDIT_MIN)) && (deb[1] ^ deb[2]) && !(|strobe);
   assign rpt = run && (rcnt == (first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));
   // times the initial hold delay, then the repeat interval, of a single held direction key
   always_ff @(posedge CLOCK_50 or negedge rst_n)
      if (!rst_n) begin
         rcnt <= '0;
         first <= 1'b1;
      end else if (!run || rpt) begin
         rcnt <= '0;
         first <= !run;
      end else begin
         rcnt <= rcnt + 1'b1;
      end
`else
   logic unused_rpt;
   assign rpt = 1'b0;
   assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
`endif
   // edit state machine with registered edit values, load pulse and blink phase
   always_ff @(posedge CLOCK_50 or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         edit_hour <= '0;
         edit_min <= '0;
         load <= 1'b0;
         editing <= 1'b0;
         lcnt <= '0;
         bcnt <= '0;
         phase <= 1'b0;
      end else begin
         bcnt <= chg || (bcnt == BW'(BLINK_CYCLES - 1)) ? '0 : bcnt + 1'b1;
         phase <= chg ? 1'b1 : (bcnt == BW'(BLINK_CYCLES - 1)) ? ~phase : phase;
         case (state)
            IDLE:
               if (mode_s) begin
                  state <= EDIT_HOUR;
                  edit_hour <= cur_hour;
                  edit_min <= cur_min;
                  editing <= 1'b1;
               end
            EDIT_HOUR:
               if (mode_s) state <= EDIT_MIN;
               else if (step_up) edit_hour <= (edit_hour >= 5'd23) ? '0 : edit_hour + 5'd1;
               else if (step_dn) edit_hour <= (edit_hour == 5'd0) ? 5'd23 : edit_hour - 5'd1;
            EDIT_MIN:
               if (mode_s) begin
                  state <= COMMIT;
                  editing <= 1'b0;
                  load <= 1'b1;
                  lcnt <= '0;
               end
               else if (step_up) edit_min <= (edit_min >= 6'd59) ? '0 : edit_min + 6'd1;
               else if (step_dn) edit_min <= (edit_min == 6'd0) ? 6'd59 : edit_min - 6'd1;
            default:
               if (load_done) begin
                  state <= IDLE;
                  load <= 1'b0;
               end else begin
                  lcnt <= lcnt + 1'b1;
               end
         endcase
      end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed bench for time_set_ctrl with small timing parameters.
module tb_time_set_ctrl;
   localparam logic [2:0] MODE = 3'b001, UP = 3'b010, DN = 3'b100;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [2:0] key_n = 3'b111;
   logic [4:0] cur_hour = 5'd22;
   logic [5:0] cur_min = 6'd58;
   logic [4:0] edit_hour;
   logic [5:0] edit_min;
   logic load, editing, blink_hour, blink_min;
   int checks = 0, errors = 0;
   int n, bh, bm;
   always #5 clk = ~clk;
   time_set_ctrl #(.DEBOUNCE_CYCLES(4), .LOAD_CYCLES(20), .BLINK_CYCLES(8), .REPEAT_DELAY(10), .REPEAT_RATE(5)) dut (
      .CLOCK_50(clk), .rst_n(rst_n), .key_mode_n(key_n[0]), .key_up_n(key_n[1]), .key_down_n(key_n[2]),
      .cur_hour(cur_hour), .cur_min(cur_min), .edit_hour(edit_hour), .edit_min(edit_min),
      .load(load), .editing(editing), .blink_hour(blink_hour), .blink_min(blink_min));
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic cyc(input int c);
      repeat (c) @(negedge clk);
   endtask
   task automatic press(input logic [2:0] k);
      key_n = ~k;
      cyc(10);
      key_n = 3'b111;
      cyc(10);
   endtask
   task automatic blink_count(output int h, output int m);
      h = 0;
      m = 0;
      for (int i = 0; i < 32; i++) begin
         cyc(1);
         h += int'(blink_hour);
         m += int'(blink_min);
      end
   endtask
   task automatic wait_load_rise();
      n = 0;
      while (!load && n < 50) begin
         cyc(1);
         n++;
      end
      check("load_rise", load, 1);
   endtask
   task automatic wait_load_fall(output int len);
      len = 0;
      while (load && len < 50) begin
         cyc(1);
         len++;
      end
   endtask
   initial begin
      cyc(3);
      check("rst_edit_hour", edit_hour, 0);
      check("rst_edit_min", edit_min, 0);
      check("rst_load", load, 0);
      check("rst_editing", editing, 0);
      check("rst_blink", {blink_hour, blink_min}, 0);
      rst_n = 1'b1;
      cyc(2);
      press(MODE);
      check("enter_editing", editing, 1);
      check("copy_hour", edit_hour, 22);
      check("copy_min", edit_min, 58);
      blink_count(bh, bm);
      check("blink_hour_cnt", bh, 16);
      check("blink_min_off", bm, 0);
      press(UP);
      check("hour_up_23", edit_hour, 23);
      press(UP);
      check("hour_wrap_0", edit_hour, 0);
      press(MODE);
      check("min_kept", edit_min, 58);
      blink_count(bh, bm);
      check("blink_hour_off", bh, 0);
      check("blink_min_cnt", bm, 16);
      press(UP);
      check("min_up_59", edit_min, 59);
      press(UP);
      check("min_wrap_0", edit_min, 0);
      check("min_no_carry", edit_hour, 0);
      key_n = ~MODE;
      wait_load_rise();
      check("commit_editing", editing, 0);
      key_n = 3'b111;
      wait_load_fall(n);
      check("load_len", n, 20);
      check("idle_hour", edit_hour, 0);
      check("idle_min", edit_min, 0);
      cur_hour = 5'd0;
      cur_min = 6'd0;
      press(UP);
      check("idle_up_hour", edit_hour, 0);
      check("idle_up_min", edit_min, 0);
      check("idle_editing", editing, 0);
      cur_hour = 5'd9;
      press(MODE);
      check("copy_hour9", edit_hour, 9);
      cur_hour = 5'd0;
      press(MODE);
      press(MODE);
      key_n = ~MODE;
      wait_load_rise();
      key_n = 3'b111;
      wait_load_fall(n);
      press(MODE);
      press(DN);
      check("hour_dn_wrap", edit_hour, 23);
      press(DN);
      check("hour_dn_22", edit_hour, 22);
      for (int i = 0; i < 5; i++) begin
         key_n = ~UP;
         cyc(3);
         key_n = 3'b111;
         cyc(3);
      end
      check("bounce_none", edit_hour, 22);
      press(UP);
      check("bounce_one", edit_hour, 23);
      press(MODE | UP);
      check("mode_wins_hour", edit_hour, 23);
      check("mode_wins_min", edit_min, 0);
      press(DN);
      check("min_dn_wrap", edit_min, 59);
      check("min_dn_hour", edit_hour, 23);
      press(UP | DN);
      check("both_no_change", edit_min, 59);
      press(UP);
      check("in_edit_min", edit_min, 0);
      key_n = ~MODE;
      wait_load_rise();
      key_n = ~UP;
      cyc(8);
      key_n = 3'b111;
      wait_load_fall(n);
      check("commit_up_len", n, 12);
      check("commit_up_hour", edit_hour, 23);
      check("commit_up_min", edit_min, 0);
      cur_min = 6'd57;
      press(MODE);
      press(MODE);
`ifdef TSET_AUTOREPEAT_EN
      key_n = ~UP;
      n = 0;
      while (edit_min != 6'd58 && n < 50) begin
         cyc(1);
         n++;
      end
      check("rep_first", edit_min, 58);
      cyc(9);
      check("rep_c9", edit_min, 58);
      cyc(1);
      check("rep_c10", edit_min, 59);
      cyc(5);
      check("rep_c15", edit_min, 0);
      key_n = 3'b111;
      cyc(5);
      check("rep_c20", edit_min, 1);
      cyc(40);
      check("rep_stop", edit_min, 1);
`else
      key_n = ~UP;
      cyc(40);
      check("hold_one_step", edit_min, 58);
      key_n = 3'b111;
      cyc(10);
      check("hold_released", edit_min, 58);
`endif
      key_n = ~MODE;
      wait_load_rise();
      #2 rst_n = 1'b0;
      #1;
      check("async_load", load, 0);
      check("async_hour", edit_hour, 0);
      check("async_min", edit_min, 0);
      check("async_editing", editing, 0);
      key_n = 3'b111;
      cyc(2);
      rst_n = 1'b1;
      cyc(30);
      check("after_rst_load", load, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
